// File: rtl/avmm_ram_bridge_burst.sv
// avmm_ram_bridge_burst
// Avalon-MM slave that spreads a linear word address space over NBANK
// single-port RAM banks. Supports incrementing read/write bursts, byte
// enables, and returns read data with a fixed latency of PL cycles.
`timescale 1ns/1ps
module avmm_ram_bridge_burst #(
  parameter int AW    = 12,
  parameter int DW    = 32,
  parameter int PL    = 2,
  parameter int NBANK = 1,
  parameter int BCW   = 4,
  localparam int BW   = (NBANK > 1) ? $clog2(NBANK) : 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW+BW-1:0]      avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [DW-1:0]         avs_writedata,
  input  logic [DW/8-1:0]       avs_byteenable,
  input  logic [BCW-1:0]        avs_burstcount,
  output logic                  avs_waitrequest,
  output logic [DW-1:0]         avs_readdata,
  output logic                  avs_readdatavalid,
  output logic                  mem_clock,
  output logic                  mem_aclr,
  output logic [NBANK-1:0]      mem_rden,
  output logic [NBANK-1:0]      mem_wren,
  output logic [AW-1:0]         mem_address,
  output logic [DW-1:0]         mem_data,
  output logic [DW/8-1:0]       mem_byteena,
  input  logic [NBANK*DW-1:0]   mem_q
);

  // Bank index needs at least one bit even when there is a single bank.
  localparam int BWI = (BW > 0) ? BW : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [AW+BW-1:0]        ba_q, ba_d;
  logic [BCW-1:0]          rc_q, rc_d;
  logic [PL-1:0]           vld_q, vld_d;
  logic [PL-1:0][BWI-1:0]  bank_pipe_q, bank_pipe_d;
  logic [DW-1:0]           rdata_q, rdata_d;

  logic [BCW-1:0]          bc_eff;
  logic                    multi_beat;
  logic                    wait_c;
  logic                    rd_issue;
  logic                    wr_issue;
  logic [AW+BW-1:0]        iss_addr;
  logic [BWI-1:0]          iss_bank;
  logic [DW-1:0]           bank_rdata [NBANK];

  // A burstcount of zero behaves exactly like a single-beat access.
  assign bc_eff     = (avs_burstcount == '0) ? BCW'(1) : avs_burstcount;
  assign multi_beat = (bc_eff > BCW'(1));

  // Bank select comes from the address bits above the per-bank word address.
  if (BW == 0) begin : g_single_bank
    assign iss_bank = '0;
  end else begin : g_multi_bank
    assign iss_bank = iss_addr[AW+BW-1:AW];
  end

  // Split the flat read-data bus into one word per bank.
  for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank_rdata
    assign bank_rdata[gi] = mem_q[gi*DW +: DW];
  end

  // State register; reset abandons any burst in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: bursts start from IDLE and finish on their last issued beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (avs_write && multi_beat) begin
          state_d = WR_BURST;
        end else if (avs_read && multi_beat) begin
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (rc_q == BCW'(1)) begin
          state_d = IDLE;
        end
      end
      WR_BURST: begin
        if (avs_write && (rc_q == BCW'(1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: which access issues this cycle, to which address, and the stall.
  always_comb begin
    wait_c   = 1'b1;
    rd_issue = 1'b0;
    wr_issue = 1'b0;
    iss_addr = ba_q;
    case (state_q)
      IDLE: begin
        // Simultaneous read and write: the write wins, the read is dropped.
        wait_c   = 1'b0;
        wr_issue = avs_write;
        rd_issue = avs_read && !avs_write;
        iss_addr = avs_address;
      end
      RD_BURST: begin
        wait_c   = 1'b1;
        rd_issue = 1'b1;
      end
      WR_BURST: begin
        // Only further write beats are accepted; reads must wait.
        wait_c   = !avs_write;
        wr_issue = avs_write;
      end
      default: begin
        wait_c = 1'b1;
      end
    endcase
    if (reset) begin
      wait_c   = 1'b1;
      rd_issue = 1'b0;
      wr_issue = 1'b0;
    end
  end

  // Burst address and remaining-beat counter; the address wraps naturally.
  always_comb begin
    ba_d = ba_q;
    rc_d = rc_q;
    if (state_q == IDLE) begin
      if ((avs_write || avs_read) && multi_beat) begin
        ba_d = avs_address + (AW+BW)'(1);
        rc_d = bc_eff - BCW'(1);
      end
    end else if (rd_issue || wr_issue) begin
      ba_d = ba_q + (AW+BW)'(1);
      rc_d = rc_q - BCW'(1);
    end
  end

  // Read-return pipeline: each issued read carries its bank for PL cycles.
  always_comb begin
    vld_d          = vld_q;
    bank_pipe_d    = bank_pipe_q;
    vld_d[0]       = rd_issue;
    bank_pipe_d[0] = iss_bank;
    for (int i = 1; i < PL; i++) begin
      vld_d[i]       = vld_q[i-1];
      bank_pipe_d[i] = bank_pipe_q[i-1];
    end
  end

  // Read data follows the returning bank when valid, otherwise holds.
  always_comb begin
    rdata_d = rdata_q;
    if (vld_q[PL-1]) begin
      rdata_d = bank_rdata[bank_pipe_q[PL-1]];
    end
  end

  // Datapath registers; in-flight read returns are discarded on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ba_q        <= '0;
      rc_q        <= '0;
      vld_q       <= '0;
      bank_pipe_q <= '0;
      rdata_q     <= '0;
    end else begin
      ba_q        <= ba_d;
      rc_q        <= rc_d;
      vld_q       <= vld_d;
      bank_pipe_q <= bank_pipe_d;
      rdata_q     <= rdata_d;
    end
  end

  assign avs_waitrequest   = wait_c;
  assign avs_readdatavalid = vld_q[PL-1];
  assign avs_readdata      = rdata_d;

  assign mem_clock   = clk;
  assign mem_aclr    = reset;
  assign mem_rden    = rd_issue ? (NBANK'(1) << iss_bank) : '0;
  assign mem_wren    = wr_issue ? (NBANK'(1) << iss_bank) : '0;
  assign mem_address = iss_addr[AW-1:0];
  assign mem_data    = avs_writedata;
  assign mem_byteena = avs_byteenable;

endmodule

// File: tb/tb_avmm_ram_bridge_burst.sv
// tb_avmm_ram_bridge_burst
// Directed bench for the burst RAM bridge: 4 banks of 16 words, PL=2.
// A reference memory plus queues of expected accesses and read returns is
// checked every cycle against the RAM-side and Avalon-side outputs.
`timescale 1ns/1ps
module tb_avmm_ram_bridge_burst;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int PL    = 2;
  localparam int NBANK = 4;
  localparam int BCW   = 4;

  typedef struct {
    bit          wr;
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } iss_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [5:0]        avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic [3:0]        avs_byteenable = '0;
  logic [3:0]        avs_burstcount = '0;
  logic              avs_waitrequest;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic              mem_clock;
  logic              mem_aclr;
  logic [3:0]        mem_rden;
  logic [3:0]        mem_wren;
  logic [3:0]        mem_address;
  logic [31:0]       mem_data;
  logic [3:0]        mem_byteena;
  logic [127:0]      mem_q;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit check_en = 1'b1;

  iss_t        exp_iss [$];
  logic [31:0] exp_data [$];
  int          rd_ts [$];
  logic [31:0] ref_mem [64];

  logic [31:0] ram [NBANK][16];
  logic [31:0] qp  [NBANK][PL];

  iss_t        cmp_e;
  logic [3:0]  cmp_oh;
  int          cmp_ts;

  avmm_ram_bridge_burst #(
    .AW(AW), .DW(DW), .PL(PL), .NBANK(NBANK), .BCW(BCW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_burstcount    (avs_burstcount),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .mem_clock         (mem_clock),
    .mem_aclr          (mem_aclr),
    .mem_rden          (mem_rden),
    .mem_wren          (mem_wren),
    .mem_address       (mem_address),
    .mem_data          (mem_data),
    .mem_byteena       (mem_byteena),
    .mem_q             (mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    end
    return r;
  endfunction

  // RAM banks: synchronous write with byte enables, PL-cycle read latency.
  always @(posedge clk) begin
    for (int k = 0; k < NBANK; k++) begin
      if (mem_wren[k]) ram[k][mem_address] <= merge(ram[k][mem_address], mem_data, mem_byteena);
      for (int s = PL - 1; s > 0; s--) qp[k][s] <= qp[k][s-1];
      qp[k][0] <= mem_rden[k] ? ram[k][mem_address] : 32'hBAD0BAD0;
    end
  end

  for (genvar gk = 0; gk < NBANK; gk++) begin : g_q
    assign mem_q[gk*32 +: 32] = qp[gk][PL-1];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: RAM-side accesses in expected order, returns in order at latency PL.
  always @(negedge clk) begin
    if (!reset && check_en) begin
      if (mem_rden != 4'd0 || mem_wren != 4'd0) begin
        if (exp_iss.size() == 0) begin
          chk("unexpected_issue", {mem_wren, mem_rden}, 8'h00);
        end else begin
          cmp_e  = exp_iss.pop_front();
          cmp_oh = 4'b0001 << cmp_e.a[5:4];
          chk("issue_rden", mem_rden, cmp_e.wr ? 4'b0000 : cmp_oh);
          chk("issue_wren", mem_wren, cmp_e.wr ? cmp_oh : 4'b0000);
          chk("issue_addr", mem_address, cmp_e.a[3:0]);
          if (cmp_e.wr) begin
            chk("issue_wdata", mem_data, cmp_e.d);
            chk("issue_be", mem_byteena, cmp_e.be);
          end
        end
      end
      if (mem_rden != 4'd0) rd_ts.push_back(cyc);
      if (avs_readdatavalid) begin
        if (exp_data.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("rdata", avs_readdata, exp_data.pop_front());
          if (rd_ts.size() != 0) begin
            cmp_ts = rd_ts.pop_front();
            chk("rd_latency", cyc - cmp_ts, PL);
          end
        end
      end
    end
  end

  task automatic wr_burst(input logic [5:0] a, input logic [3:0] bcv, input int n,
                          input logic [31:0] d0, input logic [3:0] be,
                          input int stall_at, input int stall_len);
    iss_t e;
    $display("write burst addr=0x%02h burstcount=%0d beats=%0d data0=0x%08h be=%b",
             a, bcv, n, d0, be);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          // Master stall; a stray read meanwhile must be held off.
          avs_write   = 1'b0;
          avs_read    = 1'b1;
          avs_address = 6'h3F;
          @(negedge clk);
          chk("wr_stall_read_wait", avs_waitrequest, 1'b1);
          @(posedge clk); #1;
        end
        avs_read = 1'b0;
      end
      avs_write      = 1'b1;
      avs_address    = (i == 0) ? a : ~a;
      avs_burstcount = (i == 0) ? bcv : 4'd1;
      avs_writedata  = d0 + i;
      avs_byteenable = be;
      e.wr = 1'b1; e.a = a + 6'(i); e.d = d0 + i; e.be = be;
      exp_iss.push_back(e);
      ref_mem[e.a] = merge(ref_mem[e.a], e.d, be);
      @(negedge clk);
      chk("wr_wait", avs_waitrequest, 1'b0);
      @(posedge clk); #1;
    end
    avs_write = 1'b0;
  endtask

  task automatic rd_burst(input logic [5:0] a, input logic [3:0] bcv, input int n);
    iss_t e;
    int   cnt;
    $display("read burst  addr=0x%02h burstcount=%0d beats=%0d", a, bcv, n);
    avs_read       = 1'b1;
    avs_write      = 1'b0;
    avs_address    = a;
    avs_burstcount = bcv;
    for (int i = 0; i < n; i++) begin
      e.wr = 1'b0; e.a = a + 6'(i); e.d = '0; e.be = '0;
      exp_iss.push_back(e);
      exp_data.push_back(ref_mem[e.a]);
    end
    @(negedge clk);
    chk("rd_accept_wait", avs_waitrequest, 1'b0);
    @(posedge clk); #1;
    avs_read = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      cnt++;
    end
    chk("rd_burst_wait_cycles", cnt, n - 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_data.size() != 0 || exp_iss.size() != 0) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_pending", exp_data.size() + exp_iss.size(), 0);
  endtask

  initial begin
    int vcnt;
    // Reset state
    @(negedge clk);
    chk("rst_wait", avs_waitrequest, 1'b1);
    chk("rst_valid", avs_readdatavalid, 1'b0);
    chk("rst_rdata", avs_readdata, 32'h0);
    chk("rst_rden", mem_rden, 4'h0);
    chk("rst_wren", mem_wren, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single write then single read, latency PL
    wr_burst(6'h10, 4'd1, 1, 32'hDEADBEEF, 4'hF, -1, 0);
    rd_burst(6'h10, 4'd1, 1);
    drain();
    chk("lit_deadbeef_hold", avs_readdata, 32'hDEADBEEF);

    // Burst across bank 0 -> bank 1 boundary
    wr_burst(6'h0E, 4'd4, 4, 32'h10000000, 4'hF, -1, 0);
    rd_burst(6'h0E, 4'd4, 4);
    drain();
    chk("lit_bank_cross_last", avs_readdata, 32'h10000003);

    // Write burst with a two-cycle master stall after beat 2, then read immediately
    wr_burst(6'h20, 4'd4, 4, 32'h000000A0, 4'hF, 2, 2);
    rd_burst(6'h20, 4'd1, 1);
    drain();
    chk("lit_wr_stall_first", avs_readdata, 32'h000000A0);
    rd_burst(6'h20, 4'd4, 4);
    drain();
    chk("lit_wr_stall_last", avs_readdata, 32'h000000A3);

    // burstcount=0 with partial byte enables
    wr_burst(6'h05, 4'd0, 1, 32'h00000000, 4'hF, -1, 0);
    wr_burst(6'h05, 4'd0, 1, 32'hFFFFFFFF, 4'b0011, -1, 0);
    rd_burst(6'h05, 4'd0, 1);
    drain();
    chk("lit_byteenable", avs_readdata, 32'h0000FFFF);

    // Read and write together: write is serviced, read is dropped
    $display("read+write together addr=0x07");
    avs_write = 1'b1; avs_read = 1'b1; avs_address = 6'h07; avs_burstcount = 4'd1;
    avs_writedata = 32'h77777777; avs_byteenable = 4'hF;
    begin
      iss_t e;
      e.wr = 1'b1; e.a = 6'h07; e.d = 32'h77777777; e.be = 4'hF;
      exp_iss.push_back(e);
      ref_mem[6'h07] = 32'h77777777;
    end
    @(negedge clk);
    chk("rw_both_wait", avs_waitrequest, 1'b0);
    @(posedge clk); #1;
    avs_write = 1'b0; avs_read = 1'b0;
    drain();
    rd_burst(6'h07, 4'd1, 1);
    drain();
    chk("lit_rw_both", avs_readdata, 32'h77777777);

    // Address wrap at the top of the space
    wr_burst(6'h3F, 4'd2, 2, 32'hC0DE0000, 4'hF, -1, 0);
    rd_burst(6'h3F, 4'd2, 2);
    drain();
    chk("lit_wrap", avs_readdata, 32'hC0DE0001);

    // Reset during cycle 2 of an 8-beat read burst
    $display("read burst  addr=0x30 burstcount=8 interrupted by reset");
    check_en = 1'b0;
    avs_read = 1'b1; avs_address = 6'h30; avs_burstcount = 4'd8;
    @(posedge clk); #1;
    avs_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    avs_read = 1'b1;
    @(negedge clk);
    chk("midrst_wait", avs_waitrequest, 1'b1);
    chk("midrst_valid", avs_readdatavalid, 1'b0);
    chk("midrst_rdata", avs_readdata, 32'h0);
    chk("midrst_rden", mem_rden, 4'h0);
    chk("midrst_wren", mem_wren, 4'h0);
    @(posedge clk); #1;
    avs_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_iss.delete();
    exp_data.delete();
    rd_ts.delete();
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (avs_readdatavalid) vcnt++;
      if (mem_rden != 4'd0) vcnt++;
    end
    chk("post_reset_activity", vcnt, 0);
    check_en = 1'b1;
    @(posedge clk); #1;
    rd_burst(6'h10, 4'd1, 1);
    drain();
    chk("lit_after_reset", avs_readdata, 32'h10000002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
